alu_mc: RTL

Parametrised multi-cycle ALU: the next-generation execute unit, generalised from the fixed 32-bit combinational ALU. Adds a registered result with status flags, signed compare and arithmetic shift, and iterative unsigned multiply/divide. Sits between operand read and writeback. Uses a valid/ready handshake on both sides so the control unit can stall on long operations.

---
 rtl/alu_mc.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with registered result and flags.
// Single-cycle ops finish at accept; mul/div iterate one bit per cycle.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_c;
   logic               sc_v;

   assign shamt = b[SHW-1:0];
   assign sum   = {1'b0, a} + {1'b0, b};
   assign dif   = {1'b0, a} - {1'b0, b};

   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      unique case (alu_op)
         4'd0: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            sc_res = dif[WIDTH-1:0];
            sc_c   = dif[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (dif[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2:  sc_res = a & b;
         4'd3:  sc_res = a | b;
         4'd4:  sc_res = a ^ b;
         4'd5:  sc_res = a << shamt;
         4'd6:  sc_res = a >> shamt;
         4'd7:  sc_res = ~a;
         4'd8:  sc_res = $signed(a) >>> shamt;
         4'd9:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
         4'd10: sc_res = {{(WIDTH-1){1'b0}}, a < b};
         default: sc_res = '0;
      endcase
   end

   // Shift-add: low half holds the remaining multiplier bits.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nx;

   assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, b_q} : '0);
   assign prod_nx = {mul_sum, prod_q[WIDTH-1:1]};

   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_sub;
   logic             div_ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;

   assign div_sh  = {rem_q, quo_q[WIDTH-1]};
   assign div_ge  = div_sh >= {1'b0, b_q};
   assign div_sub = div_sh - {1'b0, b_q};
   assign rem_nx  = div_ge ? div_sub[WIDTH-1:0]
                           : div_sh[WIDTH-1:0];
   assign quo_nx  = {quo_q[WIDTH-2:0], div_ge};

   logic is_mul;
   logic is_div;

   assign is_mul = (alu_op == 4'd11) || (alu_op == 4'd12);
   assign is_div = (alu_op == 4'd13) || (alu_op == 4'd14);

   logic [WIDTH-1:0] mc_res;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      b_d     = b_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      out_d   = out_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      mc_res  = '0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (is_mul) begin
                  state_d = MUL;
                  cnt_d   = CNT_LAST;
                  hi_d    = ~alu_op[0];
                  b_d     = b;
                  prod_d  = {{WIDTH{1'b0}}, a};
               end else if (is_div) begin
                  state_d = DIV;
                  cnt_d   = CNT_LAST;
                  hi_d    = ~alu_op[0];
                  b_d     = b;
                  rem_d   = '0;
                  quo_d   = a;
               end else begin
                  state_d = DONE;
                  out_d   = sc_res;
                  zero_d  = (sc_res == '0);
                  carry_d = sc_c;
                  ovf_d   = sc_v;
               end
            end
         end
         MUL: begin
            prod_d = prod_nx;
            if (cnt_q == '0) begin
               mc_res  = hi_q ? prod_nx[2*WIDTH-1:WIDTH]
                              : prod_nx[WIDTH-1:0];
               state_d = DONE;
               out_d   = mc_res;
               zero_d  = (mc_res == '0);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - SHW'(1);
            end
         end
         DIV: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            if (cnt_q == '0) begin
               mc_res  = hi_q ? rem_nx : quo_nx;
               state_d = DONE;
               out_d   = mc_res;
               zero_d  = (mc_res == '0);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - SHW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= 1'b0;
         b_q     <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         out_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == MUL) || (state_q == DIV);
   assign alu_out   = out_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule
